// File: rtl/oqpsk_pkg.sv
// Shared O-QPSK definitions: FSM states, 802.15.4 chip table and framing constants.
// Also imported by the decision/despreader logic on the receive side.
package oqpsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD
  } tx_state_t;

  localparam int         CHIPS_PER_SYM = 32;
  localparam int         PREAMBLE_SYMS = 8;
  localparam logic [7:0] SFD_BYTE      = 8'hA7;

  // Chips c0..c31 are stored MSB-first; 8..15 are 0..7 with odd chips inverted.
  localparam logic [31:0] CHIP_TABLE [16] = '{
    32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
    32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
    32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
    32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
  };

endpackage

// File: rtl/oqpsk_phase_tx_chip_spreader.sv
// Combinational chip lookup: 4-bit symbol and 5-bit chip index to one chip bit.
module chip_spreader
  import oqpsk_pkg::*;
(
  input  logic [3:0] sym,
  input  logic [4:0] idx,
  output logic       chip
);

  logic [31:0] word;

  always_comb begin
    word = CHIP_TABLE[sym];
    chip = word[5'd31 - idx];
  end

endmodule

// File: rtl/oqpsk_phase_tx.sv
// O-QPSK transmit: bytes -> 802.15.4 chips -> MSK phase-direction bits held SPC cycles each.
// Optional preamble/SFD insertion is compiled in with macro PHASE_TX_PREAMBLE_EN.
module oqpsk_phase_tx
  import oqpsk_pkg::*;
#(
  parameter int SPC = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic       o_phase,
  output logic       o_flag,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [3:0] SMP_LAST  = 4'(SPC - 1);
  localparam logic [4:0] CHIP_LAST = 5'(CHIPS_PER_SYM - 1);
`ifdef PHASE_TX_PREAMBLE_EN
  localparam tx_state_t  FIRST_STATE = ST_PREAMBLE;
  localparam logic [2:0] PRE_LAST    = 3'(PREAMBLE_SYMS - 1);
`else
  localparam tx_state_t  FIRST_STATE = ST_PAYLOAD;
`endif

  tx_state_t  state, state_nxt;
  logic [3:0] smp_cnt, smp_nxt;
  logic [4:0] chip_cnt, chip_nxt;
  logic       nib_hi, nib_nxt;
  logic [7:0] act_byte, act_nxt, hold_byte, hold_nxt;
  logic       act_last, act_last_nxt, hold_last, hold_last_nxt;
  logic       hold_full, hold_full_nxt, last_seen, last_seen_nxt;
  logic       cur_chip, cur_nxt, parity, par_nxt;
  logic       phase_nxt, done_nxt, err_nxt;
  logic       accept, adv, chip_bit;
  logic [3:0] cur_sym, sp_sym;
  logic [4:0] sp_idx;
`ifdef PHASE_TX_PREAMBLE_EN
  logic [2:0] pre_cnt, pre_nxt;
  logic       sfd_hi, sfd_nxt;
`endif

  assign o_ready = !hold_full && !last_seen;
  assign accept  = i_valid && o_ready;
  assign o_busy  = (state != ST_IDLE);
  assign o_flag  = o_busy;

  always_comb begin
    cur_sym = nib_hi ? act_byte[7:4] : act_byte[3:0];
`ifdef PHASE_TX_PREAMBLE_EN
    if (state == ST_PREAMBLE) cur_sym = 4'h0;
    else if (state == ST_SFD) cur_sym = sfd_hi ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
`endif
  end

  // Spreader looks one chip ahead: the chip that becomes current on the next wrap.
  always_comb begin
    sp_idx = chip_cnt + 5'd1;
    sp_sym = cur_sym;
    if (state == ST_IDLE) begin
      sp_idx = 5'd0;
`ifdef PHASE_TX_PREAMBLE_EN
      sp_sym = 4'h0;
`else
      sp_sym = i_byte[3:0];
`endif
    end else if (chip_cnt == CHIP_LAST) begin
      sp_idx = 5'd0;
      case (state)
`ifdef PHASE_TX_PREAMBLE_EN
        ST_PREAMBLE: sp_sym = (pre_cnt == PRE_LAST) ? SFD_BYTE[3:0] : 4'h0;
        ST_SFD:      sp_sym = sfd_hi ? act_byte[3:0] : SFD_BYTE[7:4];
`endif
        ST_PAYLOAD:  sp_sym = !nib_hi ? act_byte[7:4] :
                              (hold_full ? hold_byte[3:0] : i_byte[3:0]);
        default:     sp_sym = 4'h0;
      endcase
    end
  end

  chip_spreader u_spreader (
    .sym  (sp_sym),
    .idx  (sp_idx),
    .chip (chip_bit)
  );

  always_comb begin
    state_nxt     = state;
    smp_nxt       = smp_cnt;
    chip_nxt      = chip_cnt;
    nib_nxt       = nib_hi;
    act_nxt       = act_byte;
    act_last_nxt  = act_last;
    hold_nxt      = hold_byte;
    hold_last_nxt = hold_last;
    hold_full_nxt = hold_full;
    last_seen_nxt = last_seen;
    phase_nxt     = o_phase;
    cur_nxt       = cur_chip;
    par_nxt       = parity;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    adv           = 1'b0;
`ifdef PHASE_TX_PREAMBLE_EN
    pre_nxt       = pre_cnt;
    sfd_nxt       = sfd_hi;
`endif
    if (state == ST_IDLE) begin
      if (accept) begin
        state_nxt     = FIRST_STATE;
        smp_nxt       = 4'd0;
        chip_nxt      = 5'd0;
        nib_nxt       = 1'b0;
        act_nxt       = i_byte;
        act_last_nxt  = i_last;
        last_seen_nxt = i_last;
        phase_nxt     = chip_bit;
        cur_nxt       = chip_bit;
        par_nxt       = 1'b0;
`ifdef PHASE_TX_PREAMBLE_EN
        pre_nxt       = 3'd0;
        sfd_nxt       = 1'b0;
`endif
      end
    end else begin
      if (accept) begin
        hold_nxt      = i_byte;
        hold_last_nxt = i_last;
        hold_full_nxt = 1'b1;
        last_seen_nxt = last_seen | i_last;
      end
      if (smp_cnt != SMP_LAST) begin
        smp_nxt = smp_cnt + 4'd1;
      end else begin
        smp_nxt  = 4'd0;
        chip_nxt = chip_cnt + 5'd1;
        adv      = 1'b1;
        if (chip_cnt == CHIP_LAST) begin
          case (state)
`ifdef PHASE_TX_PREAMBLE_EN
            ST_PREAMBLE: begin
              if (pre_cnt == PRE_LAST) state_nxt = ST_SFD;
              else pre_nxt = pre_cnt + 3'd1;
            end
            ST_SFD: begin
              if (!sfd_hi) sfd_nxt = 1'b1;
              else begin
                state_nxt = ST_PAYLOAD;
                nib_nxt   = 1'b0;
              end
            end
`endif
            ST_PAYLOAD: begin
              if (!nib_hi) begin
                nib_nxt = 1'b1;
              end else if (act_last) begin
                done_nxt      = 1'b1;
                adv           = 1'b0;
                phase_nxt     = 1'b0;
                state_nxt     = ST_IDLE;
                last_seen_nxt = 1'b0;
              end else if (hold_full || accept) begin
                // A byte arriving exactly at the decision point is taken directly.
                act_nxt       = hold_full ? hold_byte : i_byte;
                act_last_nxt  = hold_full ? hold_last : i_last;
                hold_full_nxt = 1'b0;
                nib_nxt       = 1'b0;
              end else begin
                err_nxt       = 1'b1;
                adv           = 1'b0;
                phase_nxt     = 1'b0;
                state_nxt     = ST_IDLE;
                hold_full_nxt = 1'b0;
                last_seen_nxt = 1'b0;
              end
            end
            default: begin
              adv       = 1'b0;
              phase_nxt = 1'b0;
              state_nxt = ST_IDLE;
            end
          endcase
        end
        if (adv) begin
          phase_nxt = chip_bit ^ cur_chip ^ ~parity;
          cur_nxt   = chip_bit;
          par_nxt   = ~parity;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      last_seen <= 1'b0;
      o_phase   <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_full <= hold_full_nxt;
      last_seen <= last_seen_nxt;
      o_phase   <= phase_nxt;
      o_done    <= done_nxt;
      o_err     <= err_nxt;
    end
  end

  // Position and byte registers are (re)loaded at frame start, so they carry no reset.
  always_ff @(posedge i_clk) begin
    smp_cnt   <= smp_nxt;
    chip_cnt  <= chip_nxt;
    nib_hi    <= nib_nxt;
    act_byte  <= act_nxt;
    act_last  <= act_last_nxt;
    hold_byte <= hold_nxt;
    hold_last <= hold_last_nxt;
    cur_chip  <= cur_nxt;
    parity    <= par_nxt;
`ifdef PHASE_TX_PREAMBLE_EN
    pre_cnt   <= pre_nxt;
    sfd_hi    <= sfd_nxt;
`endif
  end

endmodule
